// File: rtl/encoder_2bit_rr_pkg.sv
`default_nettype none
// ============================================================================
//  Module : encoder_2bit_rr_pkg
//  Brief  : Shared sizing and FSM state encoding for the round-robin encoder.
//  Rev    : 1.0
// ============================================================================
package encoder_2bit_rr_pkg;

    localparam int ADDR_W_DEFAULT = 2;
    localparam int N_REQ_DEFAULT  = 2 ** ADDR_W_DEFAULT;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/encoder_2bit_rr_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module : rr_pick
//  Brief  : Combinational round-robin picker: first set request at or above
//           ptr, wrapping, plus a flag for more than one request present.
//  Rev    : 1.0
// ============================================================================
module rr_pick
    import encoder_2bit_rr_pkg::*;
#(
    parameter  int ADDR_W = ADDR_W_DEFAULT,
    localparam int N_REQ  = 2 ** ADDR_W
) (
    input  logic [N_REQ-1:0]  req,
    input  logic [ADDR_W-1:0] ptr,
    output logic              any,
    output logic [ADDR_W-1:0] idx,
    output logic              multi
);

    logic [ADDR_W-1:0] w_cand;

    // Scan from the far end back toward ptr so the nearest hit is written last.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_cand = ptr + ADDR_W'(i);
            if (req[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
    end

    assign multi = ($countones(req) > 1);

endmodule
`default_nettype wire

// File: rtl/encoder_2bit_rr.sv
`default_nettype none
// ============================================================================
//  Module : encoder_2bit_rr
//  Brief  : Round-robin arbiter/encoder presenting the winning requester as a
//           registered binary address with valid/ready and one-hot ack.
//  Rev    : 1.0
// ============================================================================
module encoder_2bit_rr
    import encoder_2bit_rr_pkg::*;
#(
    parameter  int ADDR_W = ADDR_W_DEFAULT,
    localparam int N_REQ  = 2 ** ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_REQ-1:0]  i_req,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic [N_REQ-1:0]  o_ack,
    output logic              o_multi
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_multi;

    logic              w_fire;
    logic [ADDR_W-1:0] w_next_ptr;
    logic [N_REQ-1:0]  w_pick_req;
    logic [ADDR_W-1:0] w_pick_ptr;
    logic              w_pick_any;
    logic [ADDR_W-1:0] w_pick_idx;
    logic              w_pick_multi;

    assign w_fire     = (r_state == ST_GRANT) && i_ready;
    assign w_next_ptr = r_addr + ADDR_W'(1);

    always_comb begin
        o_ack = '0;
        if (w_fire) begin
            o_ack[r_addr] = 1'b1;
        end
    end

    // While granted, the picker only matters on a transfer: it then looks at
    // the remaining requests starting just past the accepted one.
    assign w_pick_req = (r_state == ST_GRANT) ? (i_req & ~o_ack) : i_req;
    assign w_pick_ptr = (r_state == ST_GRANT) ? w_next_ptr : r_ptr;

    rr_pick #(
        .ADDR_W (ADDR_W)
    ) u_rr_pick (
        .req   (w_pick_req),
        .ptr   (w_pick_ptr),
        .any   (w_pick_any),
        .idx   (w_pick_idx),
        .multi (w_pick_multi)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_addr  <= '0;
            r_multi <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_addr  <= w_pick_idx;
                        r_multi <= w_pick_multi;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_fire) begin
                        r_ptr <= w_next_ptr;
                        if (w_pick_any) begin
                            r_addr  <= w_pick_idx;
                            r_multi <= w_pick_multi;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_valid = (r_state == ST_GRANT);
    assign o_addr  = r_addr;
    assign o_multi = r_multi;

endmodule
`default_nettype wire

// File: tb/tb_encoder_2bit_rr.sv
`default_nettype none
// ============================================================================
//  Module : tb_encoder_2bit_rr
//  Brief  : Self-checking bench: directed vector table, round-robin sequence
//           and randomized traffic against a behavioural reference model.
//  Rev    : 1.0
// ============================================================================
module tb_encoder_2bit_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       ready;
    logic       valid;
    logic [1:0] addr;
    logic [3:0] ack;
    logic       multi;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    encoder_2bit_rr #(.ADDR_W(2)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_ready (ready),
        .o_valid (valid),
        .o_addr  (addr),
        .o_ack   (ack),
        .o_multi (multi)
    );

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic       v;
        logic [1:0] addr;
        logic [3:0] ack;
        logic       multi;
    } vec_t;

    localparam int N_TBL = 31;
    vec_t tbl [N_TBL];

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = 4'b0000;
        ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reference model: abstract grant state, search start and arbitration.
    bit m_valid;
    int m_addr;
    bit m_multi;
    int m_ptr;

    function automatic int arb(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic r_rst, input logic [3:0] r_req, input logic r_rdy);
        logic [3:0] rem;
        if (r_rst) begin
            m_valid = 0; m_addr = 0; m_multi = 0; m_ptr = 0;
        end else if (!m_valid) begin
            if (r_req != 4'b0000) begin
                m_addr  = arb(r_req, m_ptr);
                m_multi = ($countones(r_req) > 1);
                m_valid = 1;
            end
        end else if (r_rdy) begin
            m_ptr = (m_addr + 1) % 4;
            rem   = r_req & ~(4'b0001 << m_addr);
            if (rem != 4'b0000) begin
                m_addr  = arb(rem, m_ptr);
                m_multi = ($countones(rem) > 1);
            end else begin
                m_valid = 0;
            end
        end
    endtask

    int exp_seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        // rst, req, rdy | valid, addr, ack, multi
        tbl[0]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[1]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[2]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[3]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b1};
        tbl[4]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b1};
        tbl[5]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[6]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[7]  = '{1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0};
        tbl[8]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[9]  = '{1'b0, 4'b0011, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[10] = '{1'b0, 4'b0011, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1};
        tbl[11] = '{1'b0, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0};
        tbl[12] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[13] = '{1'b0, 4'b0101, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[14] = '{1'b0, 4'b0101, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b1};
        tbl[15] = '{1'b0, 4'b0101, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1};
        tbl[16] = '{1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0};
        tbl[17] = '{1'b0, 4'b0010, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[18] = '{1'b0, 4'b1000, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0};
        tbl[19] = '{1'b0, 4'b1000, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0};
        tbl[20] = '{1'b0, 4'b1000, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0};
        tbl[21] = '{1'b0, 4'b1000, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0};
        tbl[22] = '{1'b0, 4'b1000, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0};
        tbl[23] = '{1'b0, 4'b1000, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0};
        tbl[24] = '{1'b0, 4'b1000, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0};
        tbl[25] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[26] = '{1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[27] = '{1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0};
        tbl[28] = '{1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[29] = '{1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0};
        tbl[30] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};

        do_reset();

        for (int i = 0; i < N_TBL; i++) begin
            rst   = tbl[i].rst;
            req   = tbl[i].req;
            ready = tbl[i].rdy;
            @(negedge clk);
            chk("tbl_valid", i, 32'(valid), 32'(tbl[i].v));
            chk("tbl_ack", i, 32'(ack), 32'(tbl[i].ack));
            if (tbl[i].v) begin
                chk("tbl_addr", i, 32'(addr), 32'(tbl[i].addr));
                chk("tbl_multi", i, 32'(multi), 32'(tbl[i].multi));
            end
            @(posedge clk);
            #1;
        end

        // Round-robin: all four held, each requester drops for one cycle after its ack.
        begin
            logic [3:0] prev_ack;
            int n;
            do_reset();
            prev_ack = 4'b0000;
            n        = 0;
            ready    = 1'b1;
            for (int c = 0; c < 12 && n < 5; c++) begin
                req = 4'b1111 & ~prev_ack;
                @(negedge clk);
                if (valid) begin
                    chk("rr_addr", n, 32'(addr), 32'(exp_seq[n]));
                    chk("rr_ack", n, 32'(ack), 32'(1) << exp_seq[n]);
                    chk("rr_multi", n, 32'(multi), 32'(1));
                    n++;
                end
                prev_ack = ack;
                @(posedge clk);
                #1;
            end
            chk("rr_count", 0, 32'(n), 32'(5));
        end

        // Randomized traffic against the reference model.
        do_reset();
        model_edge(1'b1, 4'b0000, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 49) == 0);
            req   = 4'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            chk("rnd_valid", c, 32'(valid), 32'(m_valid));
            chk("rnd_ack", c, 32'(ack),
                (m_valid && ready) ? (32'(1) << m_addr) : 32'(0));
            if (m_valid) begin
                chk("rnd_addr", c, 32'(addr), 32'(m_addr));
                chk("rnd_multi", c, 32'(multi), 32'(m_multi));
            end
            @(posedge clk);
            model_edge(rst, req, ready);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
